// File: rtl/ofmap_writer_pkg.sv
// Shared widths, types and FSM encoding for the ofmap writeback block.
// W lanes of ACC_W-bit signed accumulators are requantized to N-bit
// unsigned activations and packed into one OWORD_W-bit memory word.
package ofmap_writer_pkg;

  localparam int W       = 8;
  localparam int N       = 4;
  localparam int BG      = 4;
  localparam int ACC_W   = 2*N + BG;
  localparam int AW      = 12;
  localparam int CW      = 12;
  localparam int SW      = 4;
  localparam int OWORD_W = W*N;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic [N-1:0]            act_t;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} ofw_state_t;

endpackage

// File: rtl/ofmap_writer_if.sv
// Beat input stream plus request/grant memory write port of the writer.
//   in_valid/in_ready/in_data : accumulator beats from the array
//   mem_req/mem_gnt           : write handshake, word retires on req&&gnt
//   mem_addr/mem_wdata        : write address and packed activation word
// master = upstream array + memory side, slave = ofmap_writer.
interface ofmap_writer_if;
  import ofmap_writer_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [W*ACC_W-1:0]     in_data;
  logic                   mem_req;
  logic                   mem_gnt;
  logic [AW-1:0]          mem_addr;
  logic [OWORD_W-1:0]     mem_wdata;

  modport master (
    output in_valid, in_data, mem_gnt,
    input  in_ready, mem_req, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, in_data, mem_gnt,
    output in_ready, mem_req, mem_addr, mem_wdata
  );
endinterface

// File: rtl/ofmap_writer_requant_lane.sv
// One lane of requantization: round-half-up, arithmetic right shift,
// ReLU and saturation to N unsigned bits. Purely combinational.
//   acc   : signed accumulator
//   shift : right-shift amount (0 = pass through)
//   q     : unsigned N-bit activation
module requant_lane
  import ofmap_writer_pkg::*;
(
  input  acc_t          acc,
  input  logic [SW-1:0] shift,
  output act_t          q
);

  localparam logic [SW-1:0]        SH_ONE  = {{(SW-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] ONE_EXT = {{ACC_W{1'b0}}, 1'b1};

  // One extra bit keeps acc + rounding constant from wrapping.
  logic signed [ACC_W:0] ext;
  logic signed [ACC_W:0] rnd;
  logic signed [ACC_W:0] sum;
  logic signed [ACC_W:0] t;

  always_comb begin
    ext = {acc[ACC_W-1], acc};
    rnd = '0;
    if (shift != '0) rnd = ONE_EXT << (shift - SH_ONE);
    sum = ext + rnd;
    t   = sum >>> shift;
    if (t[ACC_W])
      q = '0;
    else if (|t[ACC_W-1:N])
      q = '1;
    else
      q = t[N-1:0];
  end

endmodule

// File: rtl/ofmap_writer.sv
// Writeback end of the NPU datapath. Accepts W-lane accumulator beats,
// requantizes them, packs each beat into one word and writes the words to
// consecutive addresses starting at cfg_base through a 2-entry FIFO.
//   clk, rst             : clock, synchronous active-high reset
//   start, cfg_*         : job launch pulse and job configuration
//   busy, done           : job active, one-cycle end-of-job pulse
//   bus (slave)          : beat stream in, memory write port out
//
// state | meaning
// IDLE  | waiting for start
// RUN   | accepting beats until cfg_words have been taken
// FLUSH | draining the FIFO until cfg_words have been granted
// DONE  | one-cycle done pulse
module ofmap_writer
  import ofmap_writer_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [AW-1:0]  cfg_base,
  input  logic [CW-1:0]  cfg_words,
  input  logic [SW-1:0]  cfg_shift,
  output logic           busy,
  output logic           done,
  ofmap_writer_if.slave  bus
);

  ofw_state_t state, state_nxt;

  logic [AW-1:0] base_q;
  logic [CW-1:0] words_q;
  logic [SW-1:0] shift_q;
  logic [CW-1:0] acc_cnt, wr_cnt;
  logic [CW-1:0] acc_cnt_nxt, wr_cnt_nxt;

  logic [AW-1:0]      fifo_addr [2];
  logic [OWORD_W-1:0] fifo_data [2];
  logic               wr_ptr, rd_ptr;
  logic [1:0]         count;
  logic               full, empty, push, pop, in_ready;
  logic [OWORD_W-1:0] packed_word;

  for (genvar i = 0; i < W; i++) begin : g_lane
    requant_lane u_lane (
      .acc   (bus.in_data[i*ACC_W +: ACC_W]),
      .shift (shift_q),
      .q     (packed_word[i*N +: N])
    );
  end

  assign full     = (count == 2'd2);
  assign empty    = (count == 2'd0);
  // Ready uses the current full flag, so push never meets a full FIFO.
  assign in_ready = (state == RUN) && (acc_cnt < words_q) && !full;
  assign push     = bus.in_valid && in_ready;
  assign pop      = !empty && bus.mem_gnt;

  assign acc_cnt_nxt = acc_cnt + {{(CW-1){1'b0}}, push};
  assign wr_cnt_nxt  = wr_cnt  + {{(CW-1){1'b0}}, pop};

  assign bus.in_ready  = in_ready;
  assign bus.mem_req   = !empty;
  assign bus.mem_addr  = fifo_addr[rd_ptr];
  assign bus.mem_wdata = fifo_data[rd_ptr];
  assign busy          = (state != IDLE);
  assign done          = (state == DONE);

  // Transitions look at the post-edge counts so done lands the cycle
  // after the final grant.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (cfg_words == '0) ? DONE : RUN;
      RUN:   if (acc_cnt_nxt == words_q) state_nxt = FLUSH;
      FLUSH: if (wr_cnt_nxt == words_q) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      base_q  <= '0;
      words_q <= '0;
      shift_q <= '0;
      acc_cnt <= '0;
      wr_cnt  <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count   <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_addr[i] <= '0;
        fifo_data[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        base_q  <= cfg_base;
        words_q <= cfg_words;
        shift_q <= cfg_shift;
        acc_cnt <= '0;
        wr_cnt  <= '0;
      end else begin
        acc_cnt <= acc_cnt_nxt;
        wr_cnt  <= wr_cnt_nxt;
      end
      if (push) begin
        fifo_addr[wr_ptr] <= base_q + acc_cnt[AW-1:0];
        fifo_data[wr_ptr] <= packed_word;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ofmap_writer.sv
// Directed bench for ofmap_writer with a queue-based reference model and a
// single compare process sampling on the falling edge.
module tb_ofmap_writer;
  import ofmap_writer_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_base;
  logic [CW-1:0] cfg_words;
  logic [SW-1:0] cfg_shift;
  logic          busy, done;

  ofmap_writer_if bus();

  ofmap_writer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_words (cfg_words),
    .cfg_shift (cfg_shift),
    .busy      (busy),
    .done      (done),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int rq(input int acc, input int s);
    int num, den, t;
    if (s == 0) t = acc;
    else begin
      den = 1 << s;
      num = acc + den / 2;
      if (num >= 0) t = num / den;
      else t = -(((-num) + den - 1) / den);   // floor division
    end
    if (t < 0) return 0;
    if (t > (1 << N) - 1) return (1 << N) - 1;
    return t;
  endfunction

  function automatic logic [OWORD_W-1:0] model_word(input logic [W*ACC_W-1:0] d, input int s);
    logic [OWORD_W-1:0] w;
    int a, r;
    w = '0;
    for (int i = 0; i < W; i++) begin
      a = int'($signed(d[i*ACC_W +: ACC_W]));
      r = rq(a, s);
      w[i*N +: N] = r[N-1:0];
    end
    return w;
  endfunction

  function automatic logic [W*ACC_W-1:0] mk_beat(input int l[W]);
    logic [W*ACC_W-1:0] d;
    int v;
    d = '0;
    for (int i = 0; i < W; i++) begin
      v = l[i];
      d[i*ACC_W +: ACC_W] = v[ACC_W-1:0];
    end
    return d;
  endfunction

  // ---------------- compare process ----------------
  logic [AW-1:0]      q_addr [$];
  logic [OWORD_W-1:0] q_data [$];
  int                 q_cyc  [$];
  logic [AW-1:0]      gnt_addrs [$];
  int  cyc = 0;
  int  job_base = 0, job_shift = 0, job_words = 0, acc_k = 0, job_grants = 0;
  int  last_gnt_cyc = 0, done_cnt = 0;
  bit  done_seen = 0, strict_lat = 0, prev_wait = 0;
  logic [AW-1:0]      last_addr, prev_a;
  logic [OWORD_W-1:0] last_data, prev_d;

  always @(negedge clk) begin
    int ta, c;
    logic [AW-1:0] ea;
    logic [OWORD_W-1:0] ed;
    cyc++;
    if (rst) begin
      q_addr.delete(); q_data.delete(); q_cyc.delete();
      prev_wait = 0;
    end else begin
      if (bus.in_valid && bus.in_ready) begin
        ta = job_base + acc_k;
        q_addr.push_back(ta[AW-1:0]);
        q_data.push_back(model_word(bus.in_data, job_shift));
        q_cyc.push_back(cyc);
        acc_k++;
      end
      if (prev_wait) begin
        check("hold_req", bus.mem_req, 1);
        check("hold_addr", bus.mem_addr, prev_a);
        check("hold_data", bus.mem_wdata, prev_d);
      end
      if (bus.mem_req && bus.mem_gnt) begin
        if (q_addr.size() == 0) begin
          chk++; err++;
          $display("FAIL unexpected_write: got addr %0h expected no write", bus.mem_addr);
        end else begin
          ea = q_addr.pop_front();
          ed = q_data.pop_front();
          c  = q_cyc.pop_front();
          check("wr_addr", bus.mem_addr, ea);
          check("wr_data", bus.mem_wdata, ed);
          if (strict_lat) check("wr_latency", cyc - c, 1);
        end
        job_grants++;
        last_gnt_cyc = cyc;
        last_addr = bus.mem_addr;
        last_data = bus.mem_wdata;
        gnt_addrs.push_back(bus.mem_addr);
      end
      prev_wait = bus.mem_req && !bus.mem_gnt;
      prev_a = bus.mem_addr;
      prev_d = bus.mem_wdata;
      if (done) begin
        done_cnt++;
        done_seen = 1;
        check("busy_at_done", busy, 1);
        if (job_words > 0) begin
          check("done_after_last_gnt", cyc - last_gnt_cyc, 1);
          check("grants_at_done", job_grants, job_words);
          check("model_empty_at_done", q_addr.size(), 0);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_job(input int base, input int words, input int shift);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_base  = base[AW-1:0];
    cfg_words = words[CW-1:0];
    cfg_shift = shift[SW-1:0];
    job_base = base; job_words = words; job_shift = shift;
    acc_k = 0; job_grants = 0; done_seen = 0;
    gnt_addrs.delete();
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_beat(input logic [W*ACC_W-1:0] d, output int waited);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!bus.in_ready && waited < 200);
    if (!bus.in_ready) begin
      chk++; err++;
      $display("FAIL beat_accept_timeout: got no in_ready expected accept within 200");
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int i = 0;
    while (!done_seen && i < 400) begin
      @(negedge clk); #1;
      i++;
    end
    check({name, "_done_seen"}, done_seen, 1);
  endtask

  function automatic logic [W*ACC_W-1:0] pat_beat(input int k);
    int l[W];
    for (int i = 0; i < W; i++) l[i] = ((k*37 + i*101 + 5) % 4096) - 2048;
    return mk_beat(l);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int l1[W], l2[W];
    int w, dc;
    l1 = '{-5, 0, 5, 6, 14, 30, 60, 2047};
    l2 = '{15, 16, -1, 7, 0, 1, -2048, 2047};
    rst = 1'b1; start = 1'b0;
    cfg_base = '0; cfg_words = '0; cfg_shift = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.mem_gnt = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    @(posedge clk); #1 rst = 1'b0;

    // model pins
    check("pin_model_t1", model_word(mk_beat(l1), 2), 32'hFF842100);
    check("pin_model_t2", model_word(mk_beat(l2), 0), 32'hF01070FF);

    // basic requant
    bus.mem_gnt = 1'b1;
    start_job(12'h010, 1, 2);
    send_beat(mk_beat(l1), w);
    wait_done("t1");
    check("t1_addr", last_addr, 12'h010);
    check("t1_data", last_data, 32'hFF842100);

    // shift 0 and saturation
    start_job(12'h020, 1, 0);
    send_beat(mk_beat(l2), w);
    wait_done("t2");
    check("t2_data", last_data, 32'hF01070FF);

    // streaming, one accept per cycle, write one cycle later
    strict_lat = 1;
    start_job(12'h100, 64, 3);
    for (int k = 0; k < 64; k++) begin
      send_beat(pat_beat(k), w);
      if (w != 1) check("stream_ready_wait", w, 1);
    end
    wait_done("stream");
    strict_lat = 0;
    check("stream_grants", job_grants, 64);
    check("stream_last_addr", last_addr, 12'h13F);

    // backpressure
    bus.mem_gnt = 1'b0;
    start_job(12'h200, 16, 1);
    send_beat(pat_beat(100), w);
    send_beat(pat_beat(101), w);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      check("bp_in_ready_low", bus.in_ready, 0);
      check("bp_req_high", bus.mem_req, 1);
    end
    fork
      begin
        int ww;
        for (int k = 2; k < 16; k++) send_beat(pat_beat(100 + k), ww);
      end
      begin
        for (int j = 0; j < 40; j++) begin
          @(posedge clk); #1;
          bus.mem_gnt = (j % 3 != 2);
        end
        bus.mem_gnt = 1'b1;
      end
    join
    bus.mem_gnt = 1'b1;
    wait_done("bp");
    check("bp_grants", job_grants, 16);

    // zero-length job
    dc = done_cnt;
    start_job(12'h300, 0, 0);
    @(negedge clk);
    check("zero_done", done, 1);
    check("zero_req", bus.mem_req, 0);
    @(negedge clk);
    check("zero_done_drop", done, 0);
    check("zero_busy_drop", busy, 0);
    check("zero_req2", bus.mem_req, 0);

    // address wrap
    start_job(12'hFFE, 4, 2);
    for (int k = 0; k < 4; k++) send_beat(pat_beat(200 + k), w);
    wait_done("wrap");
    check("wrap_n", gnt_addrs.size(), 4);
    if (gnt_addrs.size() == 4) begin
      check("wrap_a0", gnt_addrs[0], 12'hFFE);
      check("wrap_a1", gnt_addrs[1], 12'hFFF);
      check("wrap_a2", gnt_addrs[2], 12'h000);
      check("wrap_a3", gnt_addrs[3], 12'h001);
    end

    // start pulse during RUN is ignored
    start_job(12'h400, 3, 1);
    send_beat(pat_beat(300), w);
    start = 1'b1; cfg_base = 12'h800; cfg_words = 12'd1; cfg_shift = 4'd0;
    send_beat(pat_beat(301), w);
    start = 1'b0;
    send_beat(pat_beat(302), w);
    wait_done("ign");
    check("ign_grants", job_grants, 3);
    check("ign_last_addr", last_addr, 12'h402);

    // reset mid-job after 3 of 8 writes
    start_job(12'h500, 8, 0);
    for (int k = 0; k < 3; k++) send_beat(pat_beat(400 + k), w);
    for (int j = 0; j < 20 && job_grants < 3; j++) @(negedge clk);
    check("mid_grants_before_rst", job_grants, 3);
    dc = done_cnt;
    send_beat(pat_beat(403), w);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_req", bus.mem_req, 0);
    check("mid_ready", bus.in_ready, 0);
    repeat (4) @(negedge clk);
    check("mid_no_done", done_cnt, dc);

    // fresh job afterwards
    start_job(12'h600, 4, 2);
    for (int k = 0; k < 4; k++) send_beat(pat_beat(500 + k), w);
    wait_done("fresh");
    check("fresh_grants", job_grants, 4);
    check("fresh_last_addr", last_addr, 12'h603);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
